// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } sup_state_t;

    localparam int RST_CYCLES_DEF    = 27;
    localparam int LOCK_TIMEOUT_DEF  = 27000;
    localparam int STABLE_CYCLES_DEF = 2700;
    localparam int MAX_RETRY_DEF     = 4;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait, stability qualification and retry/fail handling.
// Optional lock-loss statistics counter enabled by macro PLL_LOCK_STATS_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int MAX_RETRY     = MAX_RETRY_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clear_fail,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ok,
    output logic       pll_fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    sup_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d, retry_inc_s;
    logic             pll_rst_q, sys_rst_n_q, pll_ok_q, pll_fail_q;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    assign retry_inc_s = retry_q + 3'd1;

    // Next-state, counter and retry decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    state_d = PLL_RST;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc_s;
                    state_d = (retry_inc_s == 3'(MAX_RETRY)) ? FAIL : PLL_RST;
                    cnt_d   = '0;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                // A drop here is a glitch: restart without touching the counts
                if (!locked_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = 3'd0;
                end else begin
                    state_d = STABLE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            FAIL: begin
                if (clear_fail) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = 3'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with outputs registered from the current state
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= 3'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ok_q    <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_q == PLL_RST) || (state_q == FAIL);
            sys_rst_n_q <= (state_q == RUN);
            pll_ok_q    <= (state_q == RUN);
            pll_fail_q  <= (state_q == FAIL);
        end
    end

`ifdef PLL_LOCK_STATS_EN
    logic [7:0] loss_q;

    // Saturating count of lock losses while running
    always_ff @(posedge refclk) begin
        if (!rst) begin
            loss_q <= 8'd0;
        end else if ((state_q == RUN) && !locked_s && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end else begin
            loss_q <= loss_q;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_ok    = pll_ok_q;
    assign pll_fail  = pll_fail_q;
    assign retry_cnt = retry_q;

endmodule
